// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED driver. Every channel runs one of four modes (off, steady,
// bit-pattern, breathe), and a shared PWM counter applies a per-channel
// brightness to the result. A common prescaler turns the board clock into a
// slow tick. Each channel counts STEP_TICKS ticks per pattern/breathe step.
// A single-cycle write port loads one channel's configuration at a time.
//
// Parameters
//   CHANNELS     number of independent LED outputs (1..16)
//   CLK_HZ       input clock frequency
//   TICK_HZ      prescaler tick rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//   STEP_TICKS   ticks per pattern/breathe step (>= 1)
//   PWM_BITS     brightness resolution
//   PATTERN_BITS length of the per-channel blink pattern
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   WR_EN       write strobe, one cycle per write
//   WR_ADDR     target channel; writes to addresses >= CHANNELS are dropped
//   WR_MODE     0 OFF, 1 ON, 2 PATTERN, 3 BREATHE
//   WR_PATTERN  blink pattern, consumed LSB first
//   WR_DUTY     brightness (0 = dark, all-ones = fully lit)
//   LED         registered LED drive, 1 = lit
//   STEP        one-cycle pulse on every prescaler tick
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter  int CHANNELS     = 4,
  parameter  int CLK_HZ       = 16000000,
  parameter  int TICK_HZ      = 1000,
  parameter  int STEP_TICKS   = 100,
  parameter  int PWM_BITS     = 8,
  parameter  int PATTERN_BITS = 16,
  localparam int AW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [AW-1:0]           WR_ADDR,
  input  logic [1:0]              WR_MODE,
  input  logic [PATTERN_BITS-1:0] WR_PATTERN,
  input  logic [PWM_BITS-1:0]     WR_DUTY,
  output logic [CHANNELS-1:0]     LED,
  output logic                    STEP
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int IDX_W = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_TICKS - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(PATTERN_BITS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                   mode;
    logic [PATTERN_BITS-1:0] pattern;
    logic [PWM_BITS-1:0]     duty;
    logic [SC_W-1:0]         step_cnt;  // ticks since the last step
    logic [IDX_W-1:0]        idx;       // current pattern bit
    logic [PWM_BITS-1:0]     level;     // breathe brightness
    logic                    dir;       // breathe direction, 0 = rising
  } chan_t;

  localparam chan_t CHAN_RESET = '{
    mode:     MODE_OFF,
    pattern:  '0,
    duty:     PWM_MAX,
    step_cnt: '0,
    idx:      '0,
    level:    '0,
    dir:      1'b0
  };

  chan_t                ch     [CHANNELS];
  chan_t                ch_nxt [CHANNELS];
  logic [CHANNELS-1:0]  led_nxt;

  logic [PRE_W-1:0]     pre;
  logic [PWM_BITS-1:0]  pwm;
  logic                 tick;
  logic                 wr_hit;

  assign tick   = (pre == PRE_LAST);
  // Zero-extend so the range check also works when CHANNELS is a power of two.
  assign wr_hit = WR_EN && (32'(WR_ADDR) < 32'(CHANNELS));

  // PWM gate: all-ones forces the LED fully on, otherwise lit while pwm < d.
  function automatic logic gate(input logic [PWM_BITS-1:0] d,
                                input logic [PWM_BITS-1:0] p);
    return (d == PWM_MAX) || (p < d);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-channel next state: a write beats a coincident step event.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a bit unassigned and no latch can be inferred.
      ch_nxt[i] = ch[i];

      if (wr_hit && (WR_ADDR == AW'(i))) begin
        ch_nxt[i].mode     = mode_e'(WR_MODE);
        ch_nxt[i].pattern  = WR_PATTERN;
        ch_nxt[i].duty     = WR_DUTY;
        ch_nxt[i].step_cnt = '0;
        ch_nxt[i].idx      = '0;
        ch_nxt[i].level    = '0;
        ch_nxt[i].dir      = 1'b0;
      end else if (tick) begin
        if (ch[i].step_cnt == STEP_LAST) begin
          ch_nxt[i].step_cnt = '0;
          unique case (ch[i].mode)
            MODE_PATTERN: begin
              ch_nxt[i].idx = (ch[i].idx == IDX_LAST) ? '0 : ch[i].idx + 1'b1;
            end
            MODE_BREATHE: begin
              // Triangle 0..MAX..0: the direction flips on arrival at an
              // endpoint, so each endpoint is shown for exactly one step.
              if (!ch[i].dir) begin
                ch_nxt[i].level = ch[i].level + 1'b1;
                if (ch[i].level == PWM_MAX - PWM_ONE) ch_nxt[i].dir = 1'b1;
              end else begin
                ch_nxt[i].level = ch[i].level - 1'b1;
                if (ch[i].level == PWM_ONE) ch_nxt[i].dir = 1'b0;
              end
            end
            default: ;
          endcase
        end else begin
          ch_nxt[i].step_cnt = ch[i].step_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LED drive, computed from the current registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (ch[i].mode)
        MODE_OFF:     led_nxt[i] = 1'b0;
        MODE_ON:      led_nxt[i] = gate(ch[i].duty, pwm);
        MODE_PATTERN: led_nxt[i] = ch[i].pattern[ch[i].idx] & gate(ch[i].duty, pwm);
        MODE_BREATHE: led_nxt[i] = gate(ch[i].level, pwm);
        default:      led_nxt[i] = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Prescaler and PWM are free-running and ignore writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre  <= '0;
      pwm  <= '0;
      STEP <= 1'b0;
      LED  <= '0;
      // NOTE: the channel array is a handful of configuration flops, not a
      // RAM, so it is reset like any other register.
      for (int i = 0; i < CHANNELS; i++) ch[i] <= CHAN_RESET;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      pwm  <= pwm + 1'b1;
      STEP <= tick;
      LED  <= led_nxt;
      for (int i = 0; i < CHANNELS; i++) ch[i] <= ch_nxt[i];
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Drives two instances of led_pattern_gen from one write bus: a four-channel
// block and a three-channel block, so address 3 is a live channel in one and an
// out-of-range address in the other. Expected LED/STEP values come from an
// arithmetic model: prescaler and PWM phase follow from the number of edges
// since reset, and each channel's step count follows from the ticks seen since
// its last write.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int DIV   = 10;
  localparam int STEPT = 2;
  localparam int PATB  = 8;
  localparam int PMAX  = 15;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [1:0] WR_ADDR = '0;
  logic [1:0] WR_MODE = '0;
  logic [7:0] WR_PATTERN = '0;
  logic [3:0] WR_DUTY = '0;

  logic [3:0] LED;
  logic       STEP;
  logic [2:0] LED3;
  logic       STEP3;

  led_pattern_gen #(
    .CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .STEP_TICKS(2),
    .PWM_BITS(4), .PATTERN_BITS(8)
  ) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_MODE(WR_MODE),
    .WR_PATTERN(WR_PATTERN), .WR_DUTY(WR_DUTY), .LED(LED), .STEP(STEP)
  );

  led_pattern_gen #(
    .CHANNELS(3), .CLK_HZ(1000), .TICK_HZ(100), .STEP_TICKS(2),
    .PWM_BITS(4), .PATTERN_BITS(8)
  ) dut3 (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_MODE(WR_MODE),
    .WR_PATTERN(WR_PATTERN), .WR_DUTY(WR_DUTY), .LED(LED3), .STEP(STEP3)
  );

  always #5 CLK = ~CLK;

  // Channel configuration as last written, plus the edge number of that write.
  typedef struct {
    int mode;
    int pat;
    int duty;
    int w;
  } cfg_t;

  cfg_t m4 [4];
  cfg_t m3 [3];
  int   n;       // rising edges since reset release
  int   total;
  int   bad;

  // Expected LED value just after edge en for one channel.
  function automatic bit model_led(cfg_t c, int en);
    int e, pw, s, lvl;
    bit g;
    e  = en - 1;                          // state the output was computed from
    pw = e % (PMAX + 1);
    s  = (e / DIV - c.w / DIV) / STEPT;   // completed steps since the write
    g  = (c.duty == PMAX) || (pw < c.duty);
    case (c.mode)
      1: return g;
      2: return ((c.pat >> (s % PATB)) & 1) == 1 && g;
      3: begin
        lvl = s % (2 * PMAX);
        if (lvl > PMAX) lvl = 2 * PMAX - lvl;
        return (lvl == PMAX) || (pw < lvl);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m4[i] = '{0, 0, PMAX, 0};
    for (int i = 0; i < 3; i++) m3[i] = '{0, 0, PMAX, 0};
    n = 0;
  endtask

  // One clock: sample just after the edge, then book any write taken there.
  task automatic cycle();
    logic [3:0] e4;
    logic [2:0] e3;
    @(posedge CLK);
    #1;
    n++;
    for (int i = 0; i < 4; i++) e4[i] = model_led(m4[i], n);
    for (int i = 0; i < 3; i++) e3[i] = model_led(m3[i], n);
    check("led4", 32'(LED), 32'(e4));
    check("led3", 32'(LED3), 32'(e3));
    check("step4", 32'(STEP), 32'(n % DIV == 0));
    check("step3", 32'(STEP3), 32'(n % DIV == 0));
    if (WR_EN) begin
      m4[WR_ADDR] = '{int'(WR_MODE), int'(WR_PATTERN), int'(WR_DUTY), n};
      if (WR_ADDR < 2'd3)
        m3[WR_ADDR] = '{int'(WR_MODE), int'(WR_PATTERN), int'(WR_DUTY), n};
      WR_EN = 1'b0;
    end
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] m,
                    input logic [7:0] p, input logic [3:0] d);
    WR_ADDR    = a;
    WR_MODE    = m;
    WR_PATTERN = p;
    WR_DUTY    = d;
    WR_EN      = 1'b1;
    cycle();
  endtask

  initial begin
    int hi;
    total = 0;
    bad   = 0;
    model_reset();

    // Reset held: everything dark.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_led4", 32'(LED), 32'd0);
    check("rst_led3", 32'(LED3), 32'd0);
    check("rst_step", 32'(STEP), 32'd0);
    #2 RST = 1'b0;
    model_reset();

    // Idle: dark, STEP every DIV cycles starting at edge 10.
    run(200);

    // Channel 0 fully on.
    wr(2'd0, 2'd1, 8'h00, 4'd15);
    run(40);

    // Channel 1 at duty 4: four lit cycles per PWM window.
    wr(2'd1, 2'd1, 8'h00, 4'd4);
    run(20);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      hi += int'(LED[1]);
    end
    check("duty4_window", 32'(hi), 32'd4);
    wr(2'd1, 2'd1, 8'h00, 4'd0);
    run(32);

    // Channel 2 pattern written just after a STEP pulse.
    while (n % DIV != 0) cycle();
    wr(2'd2, 2'd2, 8'b1010_0011, 4'd15);
    run(320);

    // Channel 3 breathe, then restart mid-ramp.
    wr(2'd3, 2'd3, 8'($urandom), 4'($urandom));
    run(650);
    run(130);
    wr(2'd3, 2'd3, 8'($urandom), 4'($urandom));
    run(100);

    // Address 3 is out of range for the three-channel block.
    wr(2'd3, 2'd1, 8'hFF, 4'd15);
    run(30);
    wr(2'd3, 2'd2, 8'h5A, 4'd9);
    run(30);

    // Randomised configuration traffic, including back-to-back writes.
    repeat (40) begin
      wr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         8'($urandom), 4'($urandom));
      run($urandom_range(0, 40));
    end

    // Reset mid-pattern drops LED without waiting for an edge.
    wr(2'd0, 2'd1, 8'h00, 4'd15);
    wr(2'd2, 2'd2, 8'hFF, 4'd15);
    run(25);
    check("pre_rst_lit", 32'(LED[0]), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_led4", 32'(LED), 32'd0);
    check("async_rst_led3", 32'(LED3), 32'd0);
    check("async_rst_step", 32'(STEP), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    model_reset();

    // After release every channel is OFF again, then a fresh pattern runs.
    run(40);
    wr(2'd2, 2'd2, 8'b1010_0011, 4'd15);
    run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
